// File: rtl/interrupt_sequencer_if.sv
// Data-memory port shared between the interrupt sequencer and the memory arbiter.
// The sequencer drives requests (master); the memory side answers (slave).
interface interrupt_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int MEM_W = 16
);
  logic             req;
  logic             we;
  logic [PC_W-1:0]  addr;
  logic [MEM_W-1:0] wdata;
  logic [MEM_W-1:0] rdata;
  logic             ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer: pushes return PC and flags, fetches the
// ISR vector, and pops them back on RTI through the shared data-memory port.
module interrupt_sequencer #(
  parameter int PC_W      = 32,
  parameter int MEM_W     = 16,
  parameter int FLAG_W    = 4,
  parameter int DRAIN_CYC = 3,
  parameter int VEC_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                intr_in,
  input  logic                imm_in,
  input  logic                rti_in,
  input  logic [PC_W-1:0]     pc_next,
  input  logic [FLAG_W-1:0]   flags_in,
  input  logic [PC_W-1:0]     sp_in,
  interrupt_sequencer_if.master mem,
  output logic                busy,
  output logic                stall_fetch,
  output logic                flush_pipe,
  output logic                sp_dec,
  output logic                sp_inc,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_load_val,
  output logic                flags_load,
  output logic [FLAG_W-1:0]   flags_out,
  output logic                intr_ack
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DRAIN    = 4'd1;
  localparam logic [3:0] PUSH_HI  = 4'd2;
  localparam logic [3:0] PUSH_LO  = 4'd3;
  localparam logic [3:0] PUSH_FLG = 4'd4;
  localparam logic [3:0] VEC_HI   = 4'd5;
  localparam logic [3:0] VEC_LO   = 4'd6;
  localparam logic [3:0] JUMP     = 4'd7;
  localparam logic [3:0] POP_FLG  = 4'd8;
  localparam logic [3:0] POP_LO   = 4'd9;
  localparam logic [3:0] POP_HI   = 4'd10;
  localparam logic [3:0] RET      = 4'd11;

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DRAIN_CYC - 1);
  localparam logic [PC_W-1:0]  VEC_HI_ADDR  = PC_W'(VEC_ADDR);
  localparam logic [PC_W-1:0]  VEC_LO_ADDR  = VEC_HI_ADDR + PC_W'(1);

  logic [3:0]        state;
  logic [3:0]        state_d;
  logic              intr_q;
  logic              pending;
  logic              entered;
  logic [CNT_W-1:0]  cnt;
  logic [PC_W-1:0]   ret_pc;
  logic [FLAG_W-1:0] ret_flg;
  logic [PC_W-1:0]   vec;
  logic              accept;
  logic              intr_edge;

  assign intr_edge = intr_in & ~intr_q;
  // RTI outranks a pending interrupt; the immediate guard only blocks the accept.
  assign accept    = (state == IDLE) && !rti_in && pending && !imm_in;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (rti_in)      state_d = POP_FLG;
        else if (accept) state_d = DRAIN;
      end
      DRAIN:    if (cnt == CNT_LAST) state_d = PUSH_HI;
      PUSH_HI:  if (mem.ready) state_d = PUSH_LO;
      PUSH_LO:  if (mem.ready) state_d = PUSH_FLG;
      PUSH_FLG: if (mem.ready) state_d = VEC_HI;
      VEC_HI:   if (mem.ready) state_d = VEC_LO;
      VEC_LO:   if (mem.ready) state_d = JUMP;
      JUMP:     state_d = IDLE;
      POP_FLG:  if (mem.ready) state_d = POP_LO;
      POP_LO:   if (mem.ready) state_d = POP_HI;
      POP_HI:   if (mem.ready) state_d = RET;
      RET:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      intr_q  <= 1'b0;
      pending <= 1'b0;
      entered <= 1'b0;
      cnt     <= '0;
      ret_pc  <= '0;
      ret_flg <= '0;
      vec     <= '0;
    end else begin
      state   <= state_d;
      intr_q  <= intr_in;
      entered <= (state_d != state);
      // A fresh edge coinciding with an accept is a new request and must survive.
      if (intr_edge)   pending <= 1'b1;
      else if (accept) pending <= 1'b0;
      cnt <= (state == DRAIN) ? cnt + 1'b1 : '0;
      if (accept) begin
        ret_pc  <= pc_next;
        ret_flg <= flags_in;
      end
      if (mem.ready) begin
        case (state)
          VEC_HI:  vec[PC_W-1:MEM_W]    <= mem.rdata;
          VEC_LO:  vec[MEM_W-1:0]       <= mem.rdata;
          POP_FLG: ret_flg              <= mem.rdata[FLAG_W-1:0];
          POP_LO:  ret_pc[MEM_W-1:0]    <= mem.rdata;
          POP_HI:  ret_pc[PC_W-1:MEM_W] <= mem.rdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    stall_fetch = (state != IDLE);
    flush_pipe  = entered && ((state == DRAIN) || (state == POP_FLG));
    mem.req     = 1'b0;
    mem.we      = 1'b0;
    mem.addr    = '0;
    mem.wdata   = '0;
    sp_dec      = 1'b0;
    sp_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    flags_load  = 1'b0;
    flags_out   = '0;
    intr_ack    = 1'b0;
    case (state)
      PUSH_HI, PUSH_LO, PUSH_FLG: begin
        mem.req  = 1'b1;
        mem.we   = 1'b1;
        mem.addr = sp_in;
        sp_dec   = mem.ready;
        case (state)
          PUSH_HI: mem.wdata = ret_pc[PC_W-1:MEM_W];
          PUSH_LO: mem.wdata = ret_pc[MEM_W-1:0];
          default: mem.wdata = MEM_W'(ret_flg);
        endcase
      end
      VEC_HI: begin
        mem.req  = 1'b1;
        mem.addr = VEC_HI_ADDR;
      end
      VEC_LO: begin
        mem.req  = 1'b1;
        mem.addr = VEC_LO_ADDR;
      end
      JUMP: begin
        pc_load     = 1'b1;
        pc_load_val = vec;
        intr_ack    = 1'b1;
      end
      POP_FLG, POP_LO, POP_HI: begin
        mem.req  = 1'b1;
        mem.addr = sp_in + PC_W'(1);
        sp_inc   = mem.ready;
      end
      RET: begin
        pc_load     = 1'b1;
        pc_load_val = ret_pc;
        flags_load  = 1'b1;
        flags_out   = ret_flg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry, immediate guard, RTI, wait states,
// RTI/interrupt priority, mid-sequence reset and stack-pointer wrap.
module tb_interrupt_sequencer;
  localparam int PC_W  = 32;
  localparam int MEM_W = 16;
  localparam int FW    = 4;
  localparam int DRN   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, intr_in, imm_in, rti_in;
  logic [PC_W-1:0]  pc_next, sp_in;
  logic [FW-1:0]    flags_in;
  logic             busy, stall_fetch, flush_pipe, sp_dec, sp_inc;
  logic             pc_load, flags_load, intr_ack;
  logic [PC_W-1:0]  pc_load_val;
  logic [FW-1:0]    flags_out;

  interrupt_sequencer_if #(.PC_W(PC_W), .MEM_W(MEM_W)) mem_bus ();

  interrupt_sequencer #(
    .PC_W(PC_W), .MEM_W(MEM_W), .FLAG_W(FW), .DRAIN_CYC(DRN), .VEC_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .intr_in(intr_in), .imm_in(imm_in), .rti_in(rti_in),
    .pc_next(pc_next), .flags_in(flags_in), .sp_in(sp_in), .mem(mem_bus),
    .busy(busy), .stall_fetch(stall_fetch), .flush_pipe(flush_pipe),
    .sp_dec(sp_dec), .sp_inc(sp_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .flags_load(flags_load), .flags_out(flags_out), .intr_ack(intr_ack)
  );

  logic [15:0] mem_arr [0:4095];
  logic [31:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [31:0] rd_addr[$];
  int          busy_cyc, stall_cyc, flush_cnt, dec_cnt, inc_cnt, pcl_cnt, fl_cnt, ack_cnt;
  int          wait_cyc, acc_idx, stall_idx, stall_n, stall_done;
  int          check_cnt, pass_cnt;
  logic [31:0] last_pc, prev_addr, sp_nxt;
  logic [15:0] prev_wdata;
  logic [3:0]  last_flags;
  bit          hold_bad, prev_wait, busy_s, done;

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    busy_cyc = 0; stall_cyc = 0; flush_cnt = 0; dec_cnt = 0; inc_cnt = 0;
    pcl_cnt = 0; fl_cnt = 0; ack_cnt = 0; wait_cyc = 0; acc_idx = 0; stall_done = 0;
    hold_bad = 0; prev_wait = 0; last_pc = '0; last_flags = '0;
  endtask

  // One clock: memory model answers at the falling edge, activity is logged, SP follows pulses.
  task automatic step();
    @(negedge clk);
    mem_bus.rdata = mem_arr[mem_bus.addr[11:0]];
    mem_bus.ready = !(mem_bus.req && acc_idx == stall_idx && stall_done < stall_n);
    #1;
    busy_s = busy;
    if (busy) busy_cyc++;
    if (stall_fetch) stall_cyc++;
    if (flush_pipe) flush_cnt++;
    if (mem_bus.req && !mem_bus.ready) begin
      stall_done++; wait_cyc++;
      if (prev_wait && (mem_bus.addr != prev_addr || mem_bus.wdata != prev_wdata)) hold_bad = 1;
      if (sp_dec || sp_inc) hold_bad = 1;
      prev_wait = 1; prev_addr = mem_bus.addr; prev_wdata = mem_bus.wdata;
    end else prev_wait = 0;
    if (mem_bus.req && mem_bus.ready) begin
      if (mem_bus.we) begin
        wr_addr.push_back(mem_bus.addr); wr_data.push_back(mem_bus.wdata);
        mem_arr[mem_bus.addr[11:0]] = mem_bus.wdata;
      end else rd_addr.push_back(mem_bus.addr);
      acc_idx++;
    end
    if (sp_dec) dec_cnt++;
    if (sp_inc) inc_cnt++;
    if (pc_load) begin pcl_cnt++; last_pc = pc_load_val; end
    if (flags_load) begin fl_cnt++; last_flags = flags_out; end
    if (intr_ack) ack_cnt++;
    sp_nxt = sp_in;
    if (sp_dec) sp_nxt = sp_nxt - 1;
    if (sp_inc) sp_nxt = sp_nxt + 1;
    @(posedge clk); #1;
    sp_in = sp_nxt;
  endtask

  // Steps until the sequencer has been busy and has returned to IDLE (bounded).
  task automatic run_seq(input int max_cyc);
    bit seen;
    clear_log();
    seen = 0; done = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      rti_in = 1'b0;
      if (busy_s) seen = 1;
      else if (seen) begin done = 1; break; end
    end
    check_cnt++;
    if (!done) $display("FAIL seq_timeout: got busy_seen=%0d expected completion in %0d cycles", seen, max_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; intr_in = 0; imm_in = 0; rti_in = 0;
    pc_next = '0; flags_in = '0; sp_in = 32'h0000_0FFF;
    mem_bus.rdata = '0; mem_bus.ready = 1'b1;
    #12;
    check_cnt++;
    if ({busy, stall_fetch, flush_pipe, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata,
         sp_dec, sp_inc, pc_load, pc_load_val, flags_load, flags_out, intr_ack} !== '0)
      $display("FAIL reset_outputs: got busy=%b req=%b pc_load=%b pc_val=%h expected all 0",
               busy, mem_bus.req, pc_load, pc_load_val);
    else pass_cnt++;
    @(posedge clk); #1; rst = 1'b1;
    clear_log();
    repeat (3) step();
    check_cnt++;
    if (busy_cyc !== 0) $display("FAIL reset_idle: got busy cycles %0d expected 0", busy_cyc);
    else pass_cnt++;
  endtask

  task automatic test_entry();
    pc_next = 32'h0000_1234; flags_in = 4'hA; sp_in = 32'h0000_0FFF;
    intr_in = 1'b1;
    run_seq(40);
    check_cnt++;
    if (busy_cyc !== DRN + 6) $display("FAIL entry_busy: got %0d expected %0d", busy_cyc, DRN + 6);
    else pass_cnt++;
    check_cnt++;
    if (wr_addr.size() !== 3 || wr_addr[0] !== 32'h0FFF || wr_addr[1] !== 32'h0FFE || wr_addr[2] !== 32'h0FFD)
      $display("FAIL entry_push_addr: got n=%0d first=%h expected 3 at 0FFF/0FFE/0FFD", wr_addr.size(), wr_addr[0]);
    else pass_cnt++;
    check_cnt++;
    if (wr_data.size() !== 3 || wr_data[0] !== 16'h0000 || wr_data[1] !== 16'h1234 || wr_data[2] !== 16'h000A)
      $display("FAIL entry_push_data: got n=%0d %h %h expected 0000 1234 000A", wr_data.size(), wr_data[1], wr_data[2]);
    else pass_cnt++;
    check_cnt++;
    if (rd_addr.size() !== 2 || rd_addr[0] !== 32'h0 || rd_addr[1] !== 32'h1)
      $display("FAIL entry_vec_addr: got n=%0d expected reads at 0 and 1", rd_addr.size());
    else pass_cnt++;
    check_cnt++;
    if (pcl_cnt !== 1 || last_pc !== 32'h0000_0200 || ack_cnt !== 1 || fl_cnt !== 0)
      $display("FAIL entry_jump: got pc_load=%0d val=%h ack=%0d flags_load=%0d expected 1 00000200 1 0",
               pcl_cnt, last_pc, ack_cnt, fl_cnt);
    else pass_cnt++;
    check_cnt++;
    if (dec_cnt !== 3 || inc_cnt !== 0 || sp_in !== 32'h0FFC)
      $display("FAIL entry_sp: got dec=%0d inc=%0d sp=%h expected 3 0 00000FFC", dec_cnt, inc_cnt, sp_in);
    else pass_cnt++;
    check_cnt++;
    if (flush_cnt !== 1 || stall_cyc !== DRN + 6)
      $display("FAIL entry_flush_stall: got flush=%0d stall=%0d expected 1 %0d", flush_cnt, stall_cyc, DRN + 6);
    else pass_cnt++;
  endtask

  task automatic test_imm_guard();
    intr_in = 1'b0; step();
    intr_in = 1'b1; imm_in = 1'b1; pc_next = 32'h0000_2000; flags_in = 4'h5;
    step();
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL imm_hold1: got busy=%b expected 0", busy); else pass_cnt++;
    step();
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL imm_hold2: got busy=%b expected 0", busy); else pass_cnt++;
    imm_in = 1'b0; pc_next = 32'h0000_3000;
    run_seq(40);
    check_cnt++;
    if (wr_data.size() !== 3 || wr_data[1] !== 16'h3000 || wr_data[2] !== 16'h0005 || wr_addr[0] !== 32'h0FFC)
      $display("FAIL imm_ret_pc: got n=%0d lo=%h flg=%h expected 3000 0005 at 0FFC", wr_data.size(), wr_data[1], wr_data[2]);
    else pass_cnt++;
    check_cnt++;
    if (busy_cyc !== DRN + 6) $display("FAIL imm_busy: got %0d expected %0d", busy_cyc, DRN + 6); else pass_cnt++;
  endtask

  task automatic test_rti();
    sp_in = 32'h0000_0FFC;
    mem_arr[12'hFFD] = 16'h000A; mem_arr[12'hFFE] = 16'h1234; mem_arr[12'hFFF] = 16'h0000;
    intr_in = 1'b0; rti_in = 1'b1;
    run_seq(20);
    check_cnt++;
    if (busy_cyc !== 4) $display("FAIL rti_busy: got %0d expected 4", busy_cyc); else pass_cnt++;
    check_cnt++;
    if (rd_addr.size() !== 3 || rd_addr[0] !== 32'h0FFD || rd_addr[1] !== 32'h0FFE || rd_addr[2] !== 32'h0FFF)
      $display("FAIL rti_pop_addr: got n=%0d first=%h expected 0FFD 0FFE 0FFF", rd_addr.size(), rd_addr[0]);
    else pass_cnt++;
    check_cnt++;
    if (pcl_cnt !== 1 || last_pc !== 32'h0000_1234 || fl_cnt !== 1 || last_flags !== 4'hA || ack_cnt !== 0)
      $display("FAIL rti_restore: got pc=%h flags=%h loads=%0d/%0d ack=%0d expected 00001234 a 1/1 0",
               last_pc, last_flags, pcl_cnt, fl_cnt, ack_cnt);
    else pass_cnt++;
    check_cnt++;
    if (inc_cnt !== 3 || dec_cnt !== 0 || flush_cnt !== 1 || wr_addr.size() !== 0)
      $display("FAIL rti_sp: got inc=%0d dec=%0d flush=%0d writes=%0d expected 3 0 1 0",
               inc_cnt, dec_cnt, flush_cnt, wr_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    sp_in = 32'h0000_0FFF; pc_next = 32'h0000_1234; flags_in = 4'hA;
    stall_idx = 1; stall_n = 3;
    intr_in = 1'b1;
    run_seq(40);
    stall_idx = -1;
    check_cnt++;
    if (busy_cyc !== DRN + 9 || wait_cyc !== 3)
      $display("FAIL wait_busy: got busy=%0d waits=%0d expected %0d 3", busy_cyc, wait_cyc, DRN + 9);
    else pass_cnt++;
    check_cnt++;
    if (hold_bad || dec_cnt !== 3) $display("FAIL wait_hold: got hold_bad=%0d dec=%0d expected 0 3", hold_bad, dec_cnt);
    else pass_cnt++;
    check_cnt++;
    if (wr_data.size() !== 3 || wr_data[1] !== 16'h1234 || wr_addr[1] !== 32'h0FFE)
      $display("FAIL wait_push: got n=%0d lo=%h expected 1234 at 0FFE", wr_data.size(), wr_data[1]);
    else pass_cnt++;
  endtask

  task automatic test_rti_priority();
    sp_in = 32'h0000_0FFC; pc_next = 32'h0000_4444; flags_in = 4'h3;
    mem_arr[12'hFFD] = 16'h000A; mem_arr[12'hFFE] = 16'h1234; mem_arr[12'hFFF] = 16'h0000;
    intr_in = 1'b0; step();
    intr_in = 1'b1; step();
    rti_in = 1'b1;
    run_seq(20);
    check_cnt++;
    if (busy_cyc !== 4 || last_pc !== 32'h0000_1234 || ack_cnt !== 0)
      $display("FAIL prio_rti_first: got busy=%0d pc=%h ack=%0d expected 4 00001234 0", busy_cyc, last_pc, ack_cnt);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL prio_accept_after_ret: got busy=%b expected 1", busy); else pass_cnt++;
    run_seq(40);
    check_cnt++;
    if (busy_cyc !== DRN + 6 || ack_cnt !== 1 || wr_data.size() !== 3 || wr_data[1] !== 16'h4444)
      $display("FAIL prio_entry: got busy=%0d ack=%0d lo=%h expected %0d 1 4444", busy_cyc, ack_cnt, wr_data[1], DRN + 6);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    sp_in = 32'h0000_0FFF; pc_next = 32'h0000_1234; flags_in = 4'hA;
    intr_in = 1'b0; step();
    intr_in = 1'b1;
    clear_log();
    n = 0;
    while (wr_addr.size() < 2 && n < 30) begin step(); n++; end
    check_cnt++;
    if (busy !== 1'b1 || wr_addr.size() !== 2)
      $display("FAIL rstmid_reach: got busy=%b writes=%0d expected 1 2", busy, wr_addr.size());
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if ({busy, stall_fetch, flush_pipe, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata,
         sp_dec, sp_inc, pc_load, pc_load_val, flags_load, flags_out, intr_ack} !== '0)
      $display("FAIL rstmid_outputs: got busy=%b req=%b addr=%h wdata=%h expected all 0",
               busy, mem_bus.req, mem_bus.addr, mem_bus.wdata);
    else pass_cnt++;
    intr_in = 1'b0;
    clear_log();
    repeat (2) step();
    rst = 1'b1;
    repeat (4) step();
    check_cnt++;
    if (busy_cyc !== 0 || pcl_cnt !== 0 || fl_cnt !== 0 || dec_cnt !== 0 || inc_cnt !== 0)
      $display("FAIL rstmid_quiet: got busy=%0d pc_load=%0d flags_load=%0d sp=%0d/%0d expected all 0",
               busy_cyc, pcl_cnt, fl_cnt, dec_cnt, inc_cnt);
    else pass_cnt++;
  endtask

  task automatic test_sp_wrap();
    sp_in = 32'hFFFF_FFFF;
    mem_arr[0] = 16'h0005; mem_arr[1] = 16'h0200; mem_arr[2] = 16'h0003;
    rti_in = 1'b1;
    run_seq(20);
    check_cnt++;
    if (rd_addr.size() !== 3 || rd_addr[0] !== 32'h0 || rd_addr[2] !== 32'h2)
      $display("FAIL wrap_addr: got n=%0d first=%h expected 3 starting at 00000000", rd_addr.size(), rd_addr[0]);
    else pass_cnt++;
    check_cnt++;
    if (last_pc !== 32'h0003_0200 || last_flags !== 4'h5 || sp_in !== 32'h0000_0002)
      $display("FAIL wrap_restore: got pc=%h flags=%h sp=%h expected 00030200 5 00000002", last_pc, last_flags, sp_in);
    else pass_cnt++;
  endtask

  initial begin
    check_cnt = 0; pass_cnt = 0; stall_idx = -1; stall_n = 0;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 16'h0000;
    mem_arr[0] = 16'h0000; mem_arr[1] = 16'h0200;
    test_reset();
    test_entry();
    test_imm_guard();
    test_rti();
    test_wait_states();
    test_rti_priority();
    test_reset_mid();
    test_sp_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
